// File: rtl/ad_readout_pkg.sv
// Shared constants and types for the ADC readout register bank.
package ad_readout_pkg;

    localparam int ST_READY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_UDR       = 3;
    localparam int ST_W         = 4;
    localparam int WORDS_PER_CH = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_HOLD  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/ad_readout_bank_if.sv
// MCU parallel-bus read port of the ADC readout bank.
interface ad_readout_bank_if #(
    parameter int ADDR_W = 16,
    parameter int BUS_W  = 16
);
    logic              CS;
    logic              RD_EN;
    logic [ADDR_W-1:0] ADDR;
    logic [BUS_W-1:0]  RD_DATA;
    logic              RD_VALID;

    modport master (output CS, RD_EN, ADDR, input RD_DATA, RD_VALID);
    modport slave  (input CS, RD_EN, ADDR, output RD_DATA, RD_VALID);
endinterface

// File: rtl/ad_ch_status.sv
// Per-channel sticky overflow/underrun flags and the live status word.
module ad_ch_status
    import ad_readout_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fifo_empty,
    input  logic            fifo_full,
    input  logic            fifo_wr,
    input  logic            udr_set,
    input  logic            clr,
    output logic [ST_W-1:0] status
);

    logic ovf_q, ovf_d;
    logic udr_q, udr_d;
    logic ovf_set;

    assign ovf_set = fifo_wr && fifo_full;

    // A set arriving together with a read-clear must not be lost.
    always_comb begin
        ovf_d = ovf_q;
        udr_d = udr_q;
        if (ovf_set)  ovf_d = 1'b1;
        else if (clr) ovf_d = 1'b0;
        if (udr_set)  udr_d = 1'b1;
        else if (clr) udr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udr_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udr_q <= udr_d;
        end
    end

    always_comb begin
        status           = '0;
        status[ST_READY] = !fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_OVF]   = ovf_q;
        status[ST_UDR]   = udr_q;
    end

endmodule

// File: rtl/ad_readout_bank.sv
// ADC FIFO readout bank: per-channel data (pop-on-read) and status words on the MCU bus.
// Define AD_BIT_REVERSE_EN to mirror sample bits for the MSB/LSB-swapped board wiring.
//
// state   | meaning
// S_IDLE  | waiting for a fresh access (bus active edge)
// S_LATCH | result registered, pop strobe high this cycle
// S_HOLD  | result held until the bus deasserts
module ad_readout_bank
    import ad_readout_pkg::*;
#(
    parameter int                NUM_CH    = 2,
    parameter int                DATA_W    = 12,
    parameter int                BUS_W     = 16,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0006
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    ad_readout_bank_if.slave         bus,
    input  logic [NUM_CH*DATA_W-1:0] AD_FIFO_DATA,
    input  logic [NUM_CH-1:0]        AD_FIFO_EMPTY,
    input  logic [NUM_CH-1:0]        AD_FIFO_FULL,
    input  logic [NUM_CH-1:0]        AD_FIFO_WR,
    output logic [NUM_CH-1:0]        AD_FIFO_RD
);

    rd_state_e                      state_q, state_d;
    logic                           prev_act_q, prev_act_d;
    logic [BUS_W-1:0]               rd_data_q, rd_data_d;
    logic                           rd_valid_q, rd_valid_d;
    logic [NUM_CH-1:0]              pop_q, pop_d;

    logic                           bus_act;
    logic                           acc_start;
    logic [NUM_CH-1:0]              data_hit;
    logic [NUM_CH-1:0]              stat_hit;
    logic [NUM_CH-1:0]              udr_set;
    logic [NUM_CH-1:0]              st_clr;
    logic [NUM_CH-1:0][DATA_W-1:0]  samp_ord;
    logic [NUM_CH-1:0][ST_W-1:0]    ch_status;

    assign bus_act   = !bus.CS && bus.RD_EN;
    assign acc_start = bus_act && !prev_act_q && (state_q == S_IDLE);

    always_comb begin
        data_hit = '0;
        stat_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.ADDR == ADDR_W'(int'(BASE_ADDR) + WORDS_PER_CH*k))
                data_hit[k] = 1'b1;
            if (bus.ADDR == ADDR_W'(int'(BASE_ADDR) + WORDS_PER_CH*k + 1))
                stat_hit[k] = 1'b1;
        end
    end

    always_comb begin
        samp_ord = '0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef AD_BIT_REVERSE_EN
            for (int i = 0; i < DATA_W; i++)
                samp_ord[k][i] = AD_FIFO_DATA[k*DATA_W + DATA_W-1-i];
`else
            samp_ord[k] = AD_FIFO_DATA[k*DATA_W +: DATA_W];
`endif
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            ad_ch_status u_status (
                .clk        (CLK),
                .rst_n      (RST_N),
                .fifo_empty (AD_FIFO_EMPTY[g]),
                .fifo_full  (AD_FIFO_FULL[g]),
                .fifo_wr    (AD_FIFO_WR[g]),
                .udr_set    (udr_set[g]),
                .clr        (st_clr[g]),
                .status     (ch_status[g])
            );
        end
    endgenerate

    // Result, pop and sticky side effects are all decided in the access-start cycle.
    always_comb begin
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        pop_d      = '0;
        udr_set    = '0;
        st_clr     = '0;
        prev_act_d = bus_act;
        case (state_q)
            S_IDLE: begin
                if (acc_start) begin
                    state_d    = S_LATCH;
                    rd_valid_d = 1'b1;
                    rd_data_d  = '0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (data_hit[k]) begin
                            if (!AD_FIFO_EMPTY[k]) begin
                                rd_data_d = BUS_W'(samp_ord[k]);
                                pop_d[k]  = 1'b1;
                            end else begin
                                udr_set[k] = 1'b1;
                            end
                        end else if (stat_hit[k]) begin
                            rd_data_d = BUS_W'(ch_status[k]);
                            st_clr[k] = 1'b1;
                        end
                    end
                end
            end
            S_LATCH: begin
                state_d    = S_HOLD;
                rd_valid_d = bus_act;
            end
            S_HOLD: begin
                if (!bus_act) state_d = S_IDLE;
                else          rd_valid_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // prev_act resets high so an access already running at reset release is not served.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            prev_act_q <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            pop_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_act_q <= prev_act_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            pop_q      <= pop_d;
        end
    end

    assign bus.RD_DATA  = rd_data_q;
    assign bus.RD_VALID = rd_valid_q;
    assign AD_FIFO_RD   = pop_q;

endmodule

// File: tb/tb_ad_readout_bank.sv
// Bench for ad_readout_bank (4-channel build): directed literal cases plus randomized accesses.
module tb_ad_readout_bank;

    localparam int          NCH  = 4;
    localparam int          DW   = 12;
    localparam int          BW   = 16;
    localparam int          AW   = 16;
    localparam logic [15:0] BASE = 16'h0006;

    logic              clk;
    logic              rst_n;
    logic [NCH*DW-1:0] ad_data;
    logic [NCH-1:0]    ad_empty;
    logic [NCH-1:0]    ad_full;
    logic [NCH-1:0]    ad_wr;
    logic [NCH-1:0]    ad_rd;

    int checks = 0;
    int errors = 0;
    int pops [NCH];

    ad_readout_bank_if #(.ADDR_W(AW), .BUS_W(BW)) bus_if ();

    ad_readout_bank #(
        .NUM_CH(NCH), .DATA_W(DW), .BUS_W(BW), .ADDR_W(AW), .BASE_ADDR(BASE)
    ) dut (
        .CLK           (clk),
        .RST_N         (rst_n),
        .bus           (bus_if.slave),
        .AD_FIFO_DATA  (ad_data),
        .AD_FIFO_EMPTY (ad_empty),
        .AD_FIFO_FULL  (ad_full),
        .AD_FIFO_WR    (ad_wr),
        .AD_FIFO_RD    (ad_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ord(input logic [11:0] s);
        logic [15:0] r;
        r = '0;
`ifdef AD_BIT_REVERSE_EN
        for (int i = 0; i < DW; i++) r[i] = s[DW-1-i];
`else
        r[11:0] = s;
`endif
        return r;
    endfunction

    // Reference model: one transaction per fresh bus-active edge, stickies as plain flags.
    logic [15:0]    m_data;
    logic           m_valid;
    logic [NCH-1:0] m_pop;
    logic           m_prev_act, m_busy, m_first;
    logic [NCH-1:0] m_ovf, m_udr, m_clr, m_uset;
    logic           m_act;
    int             m_a, m_ch, m_off;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data = '0; m_valid = 1'b0; m_pop = '0;
            m_prev_act = 1'b1; m_busy = 1'b0; m_first = 1'b0;
            m_ovf = '0; m_udr = '0;
        end else begin
            m_act  = !bus_if.CS && bus_if.RD_EN;
            m_pop  = '0;
            m_clr  = '0;
            m_uset = '0;
            if (!m_busy) begin
                m_valid = 1'b0;
                if (m_act && !m_prev_act) begin
                    m_busy = 1'b1; m_first = 1'b1; m_valid = 1'b1; m_data = '0;
                    m_a = int'(bus_if.ADDR);
                    if (m_a >= int'(BASE) && m_a < int'(BASE) + 2*NCH) begin
                        m_off = m_a - int'(BASE);
                        m_ch  = m_off / 2;
                        if (m_off % 2 == 0) begin
                            if (ad_empty[m_ch]) m_uset[m_ch] = 1'b1;
                            else begin
                                m_data = ord(ad_data[m_ch*DW +: DW]);
                                m_pop[m_ch] = 1'b1;
                            end
                        end else begin
                            m_data = 16'(int'(!ad_empty[m_ch]) + 2*int'(ad_full[m_ch])
                                         + 4*int'(m_ovf[m_ch]) + 8*int'(m_udr[m_ch]));
                            m_clr[m_ch] = 1'b1;
                        end
                    end
                end
            end else if (m_first) begin
                m_first = 1'b0;
                m_valid = m_act;
            end else begin
                m_valid = m_act;
                if (!m_act) m_busy = 1'b0;
            end
            for (int k = 0; k < NCH; k++) begin
                m_ovf[k] = (ad_wr[k] && ad_full[k]) || (m_ovf[k] && !m_clr[k]);
                m_udr[k] = m_uset[k] || (m_udr[k] && !m_clr[k]);
            end
            m_prev_act = m_act;
        end
    end

    always @(negedge clk) begin
        chk("rd_valid", 32'(bus_if.RD_VALID), 32'(m_valid));
        chk("rd_data", 32'(bus_if.RD_DATA), 32'(m_data));
        chk("fifo_rd", 32'(ad_rd), 32'(m_pop));
        for (int k = 0; k < NCH; k++) if (ad_rd[k]) pops[k]++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_on(input logic [15:0] a);
        bus_if.CS = 1'b0; bus_if.RD_EN = 1'b1; bus_if.ADDR = a;
    endtask

    task automatic bus_off();
        bus_if.CS = 1'b1; bus_if.RD_EN = 1'b0;
    endtask

    task automatic access(input logic [15:0] a, input int n, input logic [NCH-1:0] wr_first);
        bus_on(a);
        ad_wr = wr_first;
        step();
        ad_wr = '0;
        repeat (n-1) step();
        bus_off();
        repeat (3) step();
    endtask

    int p [NCH];

    task automatic snap_pops();
        for (int k = 0; k < NCH; k++) p[k] = pops[k];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        int len;
        for (int k = 0; k < NCH; k++) pops[k] = 0;
        rst_n = 1'b0;
        bus_off();
        bus_if.ADDR = '0;
        ad_data = '0; ad_empty = '1; ad_full = '0; ad_wr = '0;
        repeat (3) step();
        chk("reset_rd_data", 32'(bus_if.RD_DATA), 32'h0);
        chk("reset_rd_valid", 32'(bus_if.RD_VALID), 32'h0);
        chk("reset_fifo_rd", 32'(ad_rd), 32'h0);
        rst_n = 1'b1;
        step();

        // Channel 0 data reads
        ad_data[0 +: DW] = 12'h801; ad_empty[0] = 1'b0;
        snap_pops();
        access(BASE, 4, '0);
        chk("ch0_data_801", 32'(bus_if.RD_DATA), 32'h0801);
        chk("ch0_pop_once_a", 32'(pops[0] - p[0]), 32'd1);
        ad_data[0 +: DW] = 12'h001;
        snap_pops();
        access(BASE, 4, '0);
`ifdef AD_BIT_REVERSE_EN
        chk("ch0_data_001", 32'(bus_if.RD_DATA), 32'h0800);
`else
        chk("ch0_data_001", 32'(bus_if.RD_DATA), 32'h0001);
`endif
        chk("ch0_pop_once_b", 32'(pops[0] - p[0]), 32'd1);

        // Underrun on empty channel 1
        snap_pops();
        access(BASE + 16'd2, 3, '0);
        chk("ch1_empty_data", 32'(bus_if.RD_DATA), 32'h0);
        chk("ch1_no_pop", 32'(pops[1] - p[1]), 32'd0);
        access(BASE + 16'd3, 3, '0);
        chk("ch1_status_udr", 32'(bus_if.RD_DATA), 32'h0008);
        access(BASE + 16'd3, 3, '0);
        chk("ch1_status_clr", 32'(bus_if.RD_DATA), 32'h0000);

        // Overflow, including a write-while-full in the clear cycle
        ad_full[0] = 1'b1; ad_wr[0] = 1'b1;
        step();
        ad_wr = '0;
        step();
        access(BASE + 16'd1, 3, 4'b0001);
        chk("ch0_status_ovf", 32'(bus_if.RD_DATA), 32'h0007);
        access(BASE + 16'd1, 3, '0);
        chk("ch0_ovf_set_wins", 32'(bus_if.RD_DATA), 32'h0007);
        ad_full[0] = 1'b0;
        access(BASE + 16'd1, 3, '0);
        chk("ch0_ovf_cleared", 32'(bus_if.RD_DATA), 32'h0001);

        // Out-of-range reads leave flags alone
        access(BASE + 16'd4, 2, '0);
        snap_pops();
        access(16'h0005, 2, '0);
        chk("oor_low_data", 32'(bus_if.RD_DATA), 32'h0);
        access(BASE + 16'(2*NCH), 2, '0);
        chk("oor_high_data", 32'(bus_if.RD_DATA), 32'h0);
        chk("oor_no_pop", 32'((pops[0]-p[0]) + (pops[1]-p[1]) + (pops[2]-p[2]) + (pops[3]-p[3])), 32'd0);
        access(BASE + 16'd5, 2, '0);
        chk("ch2_udr_kept", 32'(bus_if.RD_DATA), 32'h0008);

        // Reset during HOLD with the bus left active
        ad_data[0 +: DW] = 12'h123; ad_empty[0] = 1'b0;
        bus_on(BASE);
        repeat (3) step();
        snap_pops();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("valid_after_reset", 32'(bus_if.RD_VALID), 32'h0);
        end
        bus_off();
        repeat (2) step();
        chk("no_pop_after_reset", 32'(pops[0] - p[0]), 32'd0);
        snap_pops();
        access(BASE, 2, '0);
        chk("fresh_access_data", 32'(bus_if.RD_DATA), 32'(ord(12'h123)));
        chk("fresh_access_pop", 32'(pops[0] - p[0]), 32'd1);

        // Reset landing on the pop cycle cancels the strobe
        bus_on(BASE);
        step();
        rst_n = 1'b0;
        #1;
        chk("pop_cancelled", 32'(ad_rd), 32'h0);
        step();
        rst_n = 1'b1;
        bus_off();
        repeat (2) step();

        // Per-channel mapping
        ad_empty = '0; ad_full = '0;
        for (int k = 0; k < NCH; k++) ad_data[k*DW +: DW] = 12'(12'h0A0 + k*12'h111);
        for (int k = 0; k < NCH; k++) begin
            snap_pops();
            access(BASE + 16'(2*k), 2, '0);
            chk("map_data", 32'(bus_if.RD_DATA), 32'(ord(12'(12'h0A0 + k*12'h111))));
            for (int j = 0; j < NCH; j++)
                chk("map_pop", 32'(pops[j] - p[j]), (j == k) ? 32'd1 : 32'd0);
        end

        // Randomized accesses; compared every cycle against the model
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < NCH; k++) begin
                ad_data[k*DW +: DW] = 12'($urandom);
                ad_full[k]  = ($urandom_range(0, 3) == 0);
                ad_empty[k] = ad_full[k] ? 1'b0 : ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 9) < 8) a = BASE + 16'($urandom_range(0, 2*NCH-1));
            else                          a = 16'($urandom_range(0, 31));
            len = $urandom_range(1, 4);
            bus_on(a);
            for (int c = 0; c < len; c++) begin
                ad_wr = NCH'($urandom);
                if (c > 0) bus_if.ADDR = 16'($urandom);
                step();
            end
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            bus_off();
            ad_wr = NCH'($urandom);
            repeat ($urandom_range(2, 4)) step();
            ad_wr = '0;
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad_readout_bank.md
# ad_readout_bank

Parametrised, clocked readout register bank for the ADC sample FIFOs. Maps NUM_CH channels onto the MCU parallel-bus read window. Each channel has one data word and one status word. Every data read pops exactly one sample from that channel's first-word-fall-through FIFO. Sits between the per-channel ADC FIFOs and the bus read-data mux, and adds registered outputs, pop strobes and sticky error flags.

## Interface
Parameters:
- NUM_CH, 2, number of ADC channels
- DATA_W, 12, ADC sample width (DATA_W ≤ BUS_W)
- BUS_W, 16, bus data width
- ADDR_W, 16, bus address width
- BASE_ADDR, 16'h0006, address of channel 0 data word

Ports:
- CLK  in  1  system clock; all logic is on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- CS  in  1  bus chip select, active low, already synchronous to CLK
- RD_EN  in  1  bus read enable, active high
- ADDR  in  ADDR_W  bus address
- AD_FIFO_DATA  in  NUM_CH*DATA_W  FIFO head words; channel k is at bits [k*DATA_W +: DATA_W]
- AD_FIFO_EMPTY  in  NUM_CH  FIFO empty flags
- AD_FIFO_FULL  in  NUM_CH  FIFO full flags
- AD_FIFO_WR  in  NUM_CH  FIFO write strobes, used for overflow detection
- AD_FIFO_RD  out  NUM_CH  one-cycle pop strobes
- RD_DATA  out  BUS_W  registered read data
- RD_VALID  out  1  RD_DATA holds the result of the current access

## Operation
- Address map:
  - Channel k data word is at BASE_ADDR+2k.
  - Channel k status word is at BASE_ADDR+2k+1.
  - Any other address decodes as out of range.
- Access start: the first cycle where (!CS && RD_EN) is true and was false in the previous cycle.
- FSM states: IDLE, LATCH, HOLD.
  - IDLE -> LATCH on access start; ADDR is captured in this cycle.
  - LATCH -> HOLD unconditionally after one cycle.
  - HOLD -> IDLE when (!CS && RD_EN) drops.
- Data word read, FIFO not empty:
  - RD_DATA = zero-extended sample, with bit order set by Configuration.
  - AD_FIFO_RD[k] pulses during LATCH.
- Data word read, FIFO empty:
  - RD_DATA = 0, no pop.
  - The underrun sticky bit is set.
- Status word, bit by bit:
  - bit0 = !EMPTY
  - bit1 = FULL
  - bit2 = overflow sticky, set when AD_FIFO_WR is high while FULL is high
  - bit3 = underrun sticky
  - bits [BUS_W-1:4] = 0
- Status read returns the snapshot taken at access start, then clears both sticky bits of that channel.
- If a sticky set event and a clear land in the same cycle, set wins.
- Out-of-range read: RD_DATA = 0, no pop, no flag change.
- Each access pops at most once; holding the bus active never pops again.

## Timing
- Reset values:
  - RD_DATA = 0, RD_VALID = 0, AD_FIFO_RD = 0.
  - All sticky bits = 0, FSM in IDLE.
  - The previous-active register resets to 1, so an access already in progress at reset release is ignored until the bus deasserts.
- Latency: access start in cycle t gives RD_DATA and RD_VALID in cycle t+1. AD_FIFO_RD is high in cycle t+1 only.
- RD_DATA and RD_VALID hold through HOLD. RD_VALID drops in the cycle after the bus deasserts; RD_DATA keeps its last value.
- ADDR changes during LATCH or HOLD are ignored.
- Reset asserted mid-access:
  - All state clears immediately.
  - Any pending pop is cancelled.
  - The FIFO is not popped twice after reset release.

## Configuration
- AD_BIT_REVERSE_EN defined: sample bits are mirrored, so RD_DATA[i] = sample[DATA_W-1-i]. This compensates for the ADC data bus being wired MSB/LSB-swapped on the board.
- AD_BIT_REVERSE_EN undefined: RD_DATA[DATA_W-1:0] = sample unchanged.
- Status words are unaffected either way.

## Structure
- Package ad_readout_pkg holds:
  - status bit indices: ST_READY=0, ST_FULL=1, ST_OVF=2, ST_UDR=3
  - FSM state encodings
  - the words-per-channel constant (2)
- Sub-module ad_ch_status, one instance per channel via generate:
  - holds the overflow and underrun sticky bits
  - implements set/clear priority
  - produces the status snapshot

## Test plan
- Reset, then CH0 FIFO head 12'h801, read BASE_ADDR for 4 cycles:
  - RD_DATA = 16'h0801 with the macro undefined, 16'h0801 with it defined (palindrome).
  - Then head 12'h001: 16'h0001 undefined, 16'h0800 defined.
  - Exactly one AD_FIFO_RD[0] pulse per access.
- Empty CH1, read BASE_ADDR+2: RD_DATA = 0, no pop. Following read of BASE_ADDR+3 returns 16'h0008; a second read of BASE_ADDR+3 returns 16'h0000.
- AD_FIFO_WR[0] high with FULL[0] high, read BASE_ADDR+1: returns 16'h0007 (READY, FULL and OVF set, since a full FIFO is not empty). If another write-while-full hits the clear cycle, the next status read still shows bit2 = 1.
- Read address 16'h0005 or BASE_ADDR+2*NUM_CH: RD_DATA = 0, no AD_FIFO_RD pulse, flags unchanged.
- Assert RST_N low during HOLD, then release it with the bus still active: no pop and RD_VALID stays 0 until the bus deasserts. The next fresh access is served normally.
- NUM_CH=4 build: each channel's data and status addresses hit only that channel's FIFO and flags.
